// File: rtl/adder_pkg.sv
// adder_pkg: shared widths and types for the registered CLA adder/subtractor
package adder_pkg;
  localparam int WIDTH_DEFAULT = 16;
  localparam int SLICE = 4;
  typedef logic [15:0] word_t;
  typedef struct packed {
    logic carry;
    logic overflow;
    logic zero;
  } flags_t;
endpackage

// File: rtl/cla4_slice.sv
// cla4_slice: 4-bit carry-lookahead slice with group generate/propagate and MSB carry-in
module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co,
  output logic       g,
  output logic       p,
  output logic       c3
);
  logic [3:0] w_g, w_p;
  logic [3:0] w_c;
  assign w_g = a & b;
  assign w_p = a ^ b;
  assign w_c[0] = ci;
  assign w_c[1] = w_g[0] | (w_p[0] & ci);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & ci);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & ci);
  assign g = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
           | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
  assign p = &w_p;
  assign co = g | (p & ci);
  assign c3 = w_c[3];
  assign s = w_p ^ w_c;
endmodule

// File: rtl/adder_16bit.sv
// adder_16bit: registered add/subtract with carry, signed overflow and zero flags
// Slice carries chain through each slice's co; the final carry comes from the group G/P lookahead.
module adder_16bit
  import adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic             cin,
  input  logic             sub,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             out_valid
);
  localparam int N = WIDTH / SLICE;
  logic [WIDTH-1:0] w_b, w_s;
  logic [N:0]       w_c;
  logic [N-1:0]     w_co, w_g, w_p, w_c3;
  logic             w_gc, w_unused;
  logic [WIDTH-1:0] r_result;
  flags_t           r_flags;
  logic             r_valid;
  assign w_b = sub ? ~op2 : op2;
  assign w_c[0] = sub | cin;
  for (genvar i = 0; i < N; i++) begin : gen_slice
    cla4_slice u_slice (
      .a  (op1[SLICE*i +: SLICE]),
      .b  (w_b[SLICE*i +: SLICE]),
      .ci (w_c[i]),
      .s  (w_s[SLICE*i +: SLICE]),
      .co (w_co[i]),
      .g  (w_g[i]),
      .p  (w_p[i]),
      .c3 (w_c3[i])
    );
    assign w_c[i+1] = w_co[i];
  end
  always_comb begin
    w_gc = w_c[0];
    for (int i = 0; i < N; i++) w_gc = w_g[i] | (w_p[i] & w_gc);
  end
  // only the top slice's MSB carry matters; the lower ones are internal
  assign w_unused = &{1'b0, w_c3, w_c[N]};
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_result <= '0;
      r_flags  <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_result <= w_s;
        r_flags  <= {w_gc, w_c3[N-1] ^ w_gc, ~|w_s};
      end
    end
  end
  assign result    = r_result;
  assign carry_out = r_flags.carry;
  assign overflow  = r_flags.overflow;
  assign zero      = r_flags.zero;
  assign out_valid = r_valid;
endmodule

// File: tb/tb_adder_16bit.sv
// tb_adder_16bit: directed and random checks of adder_16bit against a behavioural model
module tb_adder_16bit;
  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, cin = 1'b0, sub = 1'b0;
  logic [15:0] op1 = '0, op2 = '0;
  logic [15:0] result;
  logic        carry_out, overflow, zero, out_valid;
  typedef struct packed {
    logic [15:0] r;
    logic c, o, z, v;
  } exp_t;
  exp_t q[$];
  exp_t m = '0;
  int errors = 0, checks = 0;

  adder_16bit dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .op1(op1), .op2(op2),
    .cin(cin), .sub(sub), .result(result), .carry_out(carry_out),
    .overflow(overflow), .zero(zero), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic compare(input string tag);
    exp_t e;
    e = q.pop_front();
    chk({tag, ".result"}, result, e.r);
    chk({tag, ".carry"}, 16'(carry_out), 16'(e.c));
    chk({tag, ".overflow"}, 16'(overflow), 16'(e.o));
    chk({tag, ".zero"}, 16'(zero), 16'(e.z));
    chk({tag, ".valid"}, 16'(out_valid), 16'(e.v));
  endtask

  task automatic step(input string tag, input logic rn, input logic v,
                      input logic [15:0] a, input logic [15:0] b,
                      input logic c, input logic s);
    logic [15:0] bb;
    logic [16:0] t;
    rst_n = rn; in_valid = v; op1 = a; op2 = b; cin = c; sub = s;
    bb = s ? ~b : b;
    t = {1'b0, a} + {1'b0, bb} + {16'b0, s | c};
    if (!rn) m = '0;
    else if (v) m = '{t[15:0], t[16], (a[15] == bb[15]) && (t[15] != a[15]), t[15:0] == 16'h0, 1'b1};
    else m.v = 1'b0;
    q.push_back(m);
    @(posedge clk);
    #1;
    compare(tag);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) step("reset", 1'b0, 1'b1, 16'd5, 16'd6, 1'b0, 1'b0);
    chk("reset_const", result, 16'h0000);
    step("add_zero", 1'b1, 1'b1, 16'd0, 16'd0, 1'b0, 1'b0);
    chk("add_zero_z", 16'(zero), 16'd1);
    step("add_10_20", 1'b1, 1'b1, 16'd10, 16'd20, 1'b0, 1'b0);
    chk("add_10_20_const", result, 16'd30);
    step("wrap", 1'b1, 1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    chk("wrap_carry", 16'(carry_out), 16'd1);
    step("cin", 1'b1, 1'b1, 16'h1234, 16'h0000, 1'b1, 1'b0);
    chk("cin_const", result, 16'h1235);
    step("ovf_pos", 1'b1, 1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    chk("ovf_pos_const", result, 16'h8000);
    chk("ovf_pos_flag", 16'(overflow), 16'd1);
    step("ovf_neg", 1'b1, 1'b1, 16'h8000, 16'h8000, 1'b0, 1'b0);
    chk("ovf_neg_flag", 16'(overflow), 16'd1);
    step("sub_5_10", 1'b1, 1'b1, 16'd5, 16'd10, 1'b1, 1'b1);
    chk("sub_5_10_const", result, 16'hFFFB);
    step("sub_eq", 1'b1, 1'b1, 16'd10, 16'd10, 1'b0, 1'b1);
    chk("sub_eq_carry", 16'(carry_out), 16'd1);
    step("sub_ovf", 1'b1, 1'b1, 16'h8000, 16'h0001, 1'b0, 1'b1);
    chk("sub_ovf_const", result, 16'h7FFF);
    step("idle", 1'b1, 1'b0, 16'hAAAA, 16'h5555, 1'b1, 1'b0);
    chk("idle_hold", result, 16'h7FFF);
    step("idle2", 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    step("pre_rst", 1'b1, 1'b1, 16'h0100, 16'h0023, 1'b0, 1'b0);
    step("mid_rst", 1'b0, 1'b1, 16'd1, 16'd2, 1'b0, 1'b0);
    chk("mid_rst_const", result, 16'h0000);
    for (int i = 0; i < 1000; i++)
      step("rand", 1'b1, ($urandom_range(0, 7) != 0), 16'($urandom), 16'($urandom),
           1'($urandom), 1'($urandom));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
